display_pager: RTL

- Upstream feeder for the 8-digit seven-segment display driver.
- Accepts a wide result word (RSA ciphertext, plaintext or key) through a valid/ready handshake and holds it.
- Presents one 32-bit page at a time on `nibbles`. Pages are stepped by a debounced push-button or by an auto-scroll timer.

---
 rtl/display_pager.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_pager.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// display_pager
//
// Upstream feeder for the 8-digit seven-segment display driver. A wide result
// word (ciphertext, plaintext or key) is captured through a valid/ready
// handshake and held. The word is shown one PAGE_W-bit page at a time on
// `nibbles`. Pages advance on a debounced push-button press or on an
// auto-scroll timer.
//
// Ports:
//   clk       in   1       system clock
//   rst_n     in   1       synchronous active-low reset
//   in_data   in   DATA_W  result word to display
//   in_valid  in   1       in_data is valid
//   in_ready  out  1       block can accept in_data (rst_n & ~hold)
//   hold      in   1       refuse new data; paging still allowed
//   btn_next  in   1       raw asynchronous push-button, active-high
//   auto_en   in   1       enable auto-scroll
//   nibbles   out  PAGE_W  current page (page 0 = least-significant word)
//   page_idx  out  PW      index of the current page
//   loaded    out  1       at least one word accepted since reset
// -----------------------------------------------------------------------------
module display_pager #(
    parameter  int DATA_W      = 128,
    parameter  int PAGE_W      = 32,
    parameter  int DEB_CYCLES  = 50000,
    parameter  int AUTO_CYCLES = 100000000,
    localparam int NUM_PAGES   = DATA_W / PAGE_W,
    localparam int PW          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    input  logic              btn_next,
    input  logic              auto_en,
    output logic [PAGE_W-1:0] nibbles,
    output logic [PW-1:0]     page_idx,
    output logic              loaded
);

    localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
    localparam logic [PW-1:0]     PAGE_LAST = PW'(NUM_PAGES - 1);

    // Held word and paging state
    logic [DATA_W-1:0] data_q_r;
    logic [PW-1:0]     page_idx_r;
    logic              loaded_r;

    // Button path
    logic              sync1_r;
    logic              btn_s_r;
    logic              btn_db_r;
    logic              btn_db_d_r;
    logic [DEB_W-1:0]  deb_cnt_r;

    // Auto-scroll timer
    logic [AUTO_W-1:0] auto_cnt_r;

    // Combinational control
    logic              in_ready_s;
    logic              accept_s;
    logic              step_btn_s;
    logic              auto_active_s;
    logic              step_auto_s;
    logic              step_raw_s;
    logic              step_s;
    logic [PAGE_W-1:0] nibbles_s;

    // Ready is forced low during reset so nothing is accepted by an edge
    // that is also resetting the block.
    assign in_ready_s    = rst_n & ~hold;
    assign accept_s      = in_valid & in_ready_s;

    // Rising edge of the debounced level only; release never steps.
    assign step_btn_s    = btn_db_r & ~btn_db_d_r;

    assign auto_active_s = auto_en & loaded_r;
    assign step_auto_s   = auto_active_s & (auto_cnt_r == AUTO_LAST);

    // Both sources collapse into one step; a load in the same cycle wins.
    assign step_raw_s    = step_btn_s | step_auto_s;
    assign step_s        = step_raw_s & loaded_r & ~accept_s;

    // Page select. NUM_PAGES need not be a power of two, so the mux compares
    // against each legal index rather than using a variable part-select.
    always_comb begin
        nibbles_s = '0;
        for (int p = 0; p < NUM_PAGES; p++) begin
            nibbles_s = (page_idx_r == PW'(p)) ? data_q_r[p*PAGE_W +: PAGE_W] : nibbles_s;
        end
    end

    // Two-flop synchroniser for the asynchronous push-button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            btn_s_r <= 1'b0;
        end else begin
            sync1_r <= btn_next;
            btn_s_r <= sync1_r;
        end
    end

    // Debouncer: the level must disagree for DEB_CYCLES consecutive cycles
    // before it is adopted; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_db_r   <= 1'b0;
            btn_db_d_r <= 1'b0;
            deb_cnt_r  <= '0;
        end else begin
            btn_db_d_r <= btn_db_r;
            if (btn_s_r != btn_db_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    btn_db_r  <= btn_s_r;
                    deb_cnt_r <= '0;
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                end
            end else begin
                deb_cnt_r <= '0;
            end
        end
    end

    // Auto-scroll timer: restarts on load, on any step, and whenever idle,
    // so a button step also pushes the next auto step a full period out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_cnt_r <= '0;
        end else if (accept_s || !auto_active_s || step_raw_s) begin
            auto_cnt_r <= '0;
        end else begin
            auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
        end
    end

    // Captured word, page index and loaded flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q_r   <= '0;
            page_idx_r <= '0;
            loaded_r   <= 1'b0;
        end else if (accept_s) begin
            data_q_r   <= in_data;
            page_idx_r <= '0;
            loaded_r   <= 1'b1;
        end else if (step_s) begin
            if (page_idx_r == PAGE_LAST) begin
                page_idx_r <= '0;
            end else begin
                page_idx_r <= page_idx_r + PW'(1);
            end
        end else begin
            page_idx_r <= page_idx_r;
        end
    end

    assign in_ready = in_ready_s;
    assign nibbles  = nibbles_s;
    assign page_idx = page_idx_r;
    assign loaded   = loaded_r;

    display_pager_checker #(
        .PW        (PW),
        .NUM_PAGES (NUM_PAGES)
    ) u_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept_s),
        .step_btn (step_btn_s),
        .page_idx (page_idx_r)
    );

endmodule

// -----------------------------------------------------------------------------
// display_pager_checker
//
// Structural invariants of display_pager. Not synthesised logic.
//
// Ports:
//   clk       in  1   system clock
//   rst_n     in  1   synchronous active-low reset
//   accept    in  1   word accepted this cycle
//   step_btn  in  1   debounced button pulse
//   page_idx  in  PW  current page index
// -----------------------------------------------------------------------------
module display_pager_checker #(
    parameter int PW        = 2,
    parameter int NUM_PAGES = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          accept,
    input logic          step_btn,
    input logic [PW-1:0] page_idx
);

    localparam logic [PW-1:0] PAGE_LAST = PW'(NUM_PAGES - 1);

    // Page index never leaves the legal range
    a_page_range: assert property (@(posedge clk) disable iff (!rst_n)
        page_idx <= PAGE_LAST);

    // A load always lands on page 0
    a_accept_page0: assert property (@(posedge clk) disable iff (!rst_n)
        accept |=> (page_idx == '0));

    // Button step is a single-cycle pulse
    a_btn_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        step_btn |=> !step_btn);

endmodule
